stream_pattern_sender: RTL and testbench

Parametrised successor to the single-pattern periodic NAP sender. It generates a DATA_W-bit pattern and sends it periodically over the t_DATA_STREAM NAP tx interface, cycling round-robin across NUM_DEST consecutive destination addresses. It has a runtime-programmable period, pattern mode, seed load, enable gating and a transfer counter. It sits between local control logic and the NAP, feeding receiver blocks elsewhere on the NoC.

---
 rtl/stream_pattern_sender_if.sv | 25 ++
 rtl/stream_pattern_sender.sv | 135 +++++++++++++
 tb/tb_stream_pattern_sender.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_pattern_sender_if.sv
// NAP data-stream channel: payload, destination address and a
// valid/ready handshake, seen from the sender (tx) or receiver (rx).
interface t_DATA_STREAM #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] data;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  valid;
  logic                  ready;

  modport tx (
    output data,
    output addr,
    output valid,
    input  ready
  );

  modport rx (
    input  data,
    input  addr,
    input  valid,
    output ready
  );
endinterface

// File: rtl/stream_pattern_sender.sv
// Periodic pattern sender: emits a DATA_W-bit pattern over a NAP tx
// channel, cycling round-robin over NUM_DEST consecutive addresses.
module stream_pattern_sender #(
  parameter int DATA_W   = 8,
  parameter int NUM_DEST = 4,
  parameter int ADDR_W   = 4,
  parameter int PERIOD_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic [1:0]          mode,
  input  logic [DATA_W-1:0]   seed,
  input  logic                load_seed,
  input  logic [ADDR_W-1:0]   dest_base,
  t_DATA_STREAM.tx            nap,
  output logic [31:0]         sent_count,
  output logic                busy
);

  localparam int IDX_W =
    (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NUM_DEST - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SEND
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   pat_q, pat_d, pat_upd;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                valid_q, valid_d;
  logic [31:0]         sent_q, sent_d;
  logic                busy_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      pat_q   <= DATA_W'(1);
      idx_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      sent_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      sent_q  <= sent_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  always_comb begin
    pat_upd = pat_q;
    unique case (mode)
      2'd0: pat_upd = (pat_q << 1)
                    | (pat_q >> (DATA_W - 1));
      2'd1: pat_upd = (pat_q >> 1)
                    | (pat_q << (DATA_W - 1));
      2'd2: pat_upd = pat_q + 1'b1;
      default: pat_upd = pat_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    sent_d  = sent_q;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          cnt_d   = period;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          data_d  = pat_q;
          addr_d  = dest_base + ADDR_W'(idx_q);
          valid_d = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        // valid stays up until accepted, even if enable drops
        if (nap.ready) begin
          valid_d = 1'b0;
          sent_d  = sent_q + 32'd1;
          pat_d   = pat_upd;
          idx_d   = (idx_q == LAST_IDX) ? '0
                  : idx_q + 1'b1;
          cnt_d   = period;
          state_d = enable ? WAIT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load_seed) pat_d = seed;
  end

  always_comb begin
    nap.data = '0;
    nap.data[DATA_W-1:0] = data_q;
    nap.addr = '0;
    nap.addr[ADDR_W-1:0] = addr_q;
    nap.valid = valid_q;
  end

  assign sent_count = sent_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_stream_pattern_sender.sv
// Directed bench for stream_pattern_sender with hand-computed
// expectations for each transfer.
module tb_stream_pattern_sender;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic [31:0] period;
  logic [1:0]  mode;
  logic [7:0]  seed;
  logic        load_seed;
  logic [3:0]  dest_base;
  logic [31:0] sent_count;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  t_DATA_STREAM #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) nap ();

  stream_pattern_sender #(
    .DATA_W(8), .NUM_DEST(4), .ADDR_W(4), .PERIOD_W(32)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .enable(enable),
    .period(period),
    .mode(mode),
    .seed(seed),
    .load_seed(load_seed),
    .dest_base(dest_base),
    .nap(nap),
    .sent_count(sent_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_d1 [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
  logic [3:0] exp_a1 [5] = '{4'hE, 4'hF, 4'h0, 4'h1, 4'hE};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, got, exp);
    end
  endtask

  task automatic wait_valid(input int n);
    for (int i = 0; i < n - 1; i++) tick();
    chk("valid_pre", 32'(nap.valid), 32'd0);
    tick();
    chk("valid_rise", 32'(nap.valid), 32'd1);
  endtask

  initial begin
    resetn    = 1'b0;
    enable    = 1'b0;
    period    = 32'd3;
    mode      = 2'd0;
    seed      = 8'h00;
    load_seed = 1'b0;
    dest_base = 4'hE;
    nap.ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", 32'(nap.valid), 32'd0);
    chk("rst_data", 32'(nap.data), 32'd0);
    chk("rst_addr", 32'(nap.addr), 32'd0);
    chk("rst_sent", sent_count, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // periodic rotate-left sends over four destinations
    resetn = 1'b1;
    enable = 1'b1;
    wait_valid(5);
    for (int k = 0; k < 5; k++) begin
      chk("t1_data", 32'(nap.data), 32'(exp_d1[k]));
      chk("t1_addr", 32'(nap.addr), 32'(exp_a1[k]));
      chk("t1_sent_pre", sent_count, 32'(k));
      tick();
      chk("t1_valid_fall", 32'(nap.valid), 32'd0);
      chk("t1_sent", sent_count, 32'(k + 1));
      if (k < 4) wait_valid(4);
    end

    // backpressure
    nap.ready = 1'b0;
    wait_valid(4);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", 32'(nap.valid), 32'd1);
      chk("bp_data", 32'(nap.data), 32'h20);
      chk("bp_addr", 32'(nap.addr), 32'hF);
      chk("bp_sent", sent_count, 32'd5);
    end
    nap.ready = 1'b1;
    tick();
    chk("bp_valid_fall", 32'(nap.valid), 32'd0);
    chk("bp_sent_after", sent_count, 32'd6);

    // rotate-right from reset
    resetn = 1'b0;
    enable = 1'b0;
    tick();
    chk("m_rst_sent", sent_count, 32'd0);
    resetn = 1'b1;
    mode   = 2'd1;
    period = 32'd0;
    enable = 1'b1;
    wait_valid(2);
    chk("rr0", 32'(nap.data), 32'h01);
    tick();
    wait_valid(1);
    chk("rr1", 32'(nap.data), 32'h80);
    tick();
    wait_valid(1);
    chk("rr2", 32'(nap.data), 32'h40);
    tick();
    enable = 1'b0;
    tick();
    chk("m_idle_busy", 32'(busy), 32'd0);

    // seed then increment with wrap
    seed      = 8'hFE;
    load_seed = 1'b1;
    mode      = 2'd2;
    tick();
    load_seed = 1'b0;
    enable    = 1'b1;
    wait_valid(2);
    chk("inc0", 32'(nap.data), 32'hFE);
    tick();
    wait_valid(1);
    chk("inc1", 32'(nap.data), 32'hFF);
    tick();
    wait_valid(1);
    chk("inc_wrap", 32'(nap.data), 32'h00);
    mode = 2'd3;
    tick();
    wait_valid(1);
    chk("hold", 32'(nap.data), 32'h00);

    // seed during SEND leaves presented data alone
    nap.ready = 1'b0;
    seed      = 8'h5A;
    load_seed = 1'b1;
    tick();
    load_seed = 1'b0;
    chk("seed_send_valid", 32'(nap.valid), 32'd1);
    chk("seed_send_data", 32'(nap.data), 32'h00);
    nap.ready = 1'b1;
    tick();
    wait_valid(1);
    chk("seed_next", 32'(nap.data), 32'h5A);

    // seed on the handshake cycle wins over mode update
    seed      = 8'hC3;
    load_seed = 1'b1;
    mode      = 2'd2;
    tick();
    load_seed = 1'b0;
    mode      = 2'd3;
    wait_valid(1);
    chk("seed_hs", 32'(nap.data), 32'hC3);
    chk("m_sent", sent_count, 32'd8);

    // enable drop in WAIT
    tick();
    enable = 1'b0;
    tick();
    chk("ew_busy", 32'(busy), 32'd0);
    chk("ew_valid", 32'(nap.valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ew_idle_valid", 32'(nap.valid), 32'd0);
    end
    chk("ew_sent", sent_count, 32'd9);

    // enable drop in SEND under backpressure
    period    = 32'd3;
    nap.ready = 1'b0;
    enable    = 1'b1;
    wait_valid(5);
    chk("es_data", 32'(nap.data), 32'hC3);
    chk("es_addr", 32'(nap.addr), 32'hF);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("es_valid_held", 32'(nap.valid), 32'd1);
      chk("es_busy_held", 32'(busy), 32'd1);
    end
    nap.ready = 1'b1;
    tick();
    chk("es_valid_fall", 32'(nap.valid), 32'd0);
    chk("es_busy_fall", 32'(busy), 32'd0);
    chk("es_sent", sent_count, 32'd10);
    tick();
    tick();
    chk("es_idle_valid", 32'(nap.valid), 32'd0);

    // period 0: a transfer every two cycles
    period = 32'd0;
    enable = 1'b1;
    wait_valid(2);
    for (int i = 0; i < 4; i++) begin
      chk("p0_valid_hi", 32'(nap.valid), 32'd1);
      tick();
      chk("p0_valid_lo", 32'(nap.valid), 32'd0);
      chk("p0_sent", sent_count, 32'(11 + i));
      tick();
    end

    // reset mid-SEND
    nap.ready = 1'b0;
    tick();
    chk("rs_valid_pre", 32'(nap.valid), 32'd1);
    resetn = 1'b0;
    tick();
    chk("rs_valid", 32'(nap.valid), 32'd0);
    chk("rs_sent", sent_count, 32'd0);
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_data", 32'(nap.data), 32'd0);
    resetn    = 1'b1;
    dest_base = 4'h3;
    period    = 32'd1;
    mode      = 2'd0;
    nap.ready = 1'b1;
    wait_valid(3);
    chk("rs_first_data", 32'(nap.data), 32'h01);
    chk("rs_first_addr", 32'(nap.addr), 32'h3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
